// File: rtl/bcd_display_driver_if.sv
// Display-side bus of the BCD seven-segment driver.
// Carries digit load, blanking and the registered segment/anode/error lines.
interface bcd_display_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      blank;
    logic [6:0]                segments;
    logic [NUM_DIGITS-1:0]     anodes;
    logic                      code_err;

    // Front-panel controller side: supplies digits, observes the display lines.
    modport master (
        output load,
        output digits_in,
        output blank,
        input  segments,
        input  anodes,
        input  code_err
    );

    // Driver side.
    modport slave (
        input  load,
        input  digits_in,
        input  blank,
        output segments,
        output anodes,
        output code_err
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Multiplexed seven-segment driver: latches packed BCD, scans one digit at a time.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module bcd_display_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input logic                  clk,
    input logic                  reset,
    bcd_display_driver_if.slave  bus
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Architectural state
    logic [DW-1:0]         digit_q, digit_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  blank_q, blank_d;

    // Registered display outputs
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  err_q, err_d;

    // Combinational helpers
    logic                  scan_adv;
    logic [3:0]            sel_code;
    logic                  sel_supp;
    logic                  lit;
    logic [NUM_DIGITS-1:0] supp;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Digit latch, prescaler and scan index next-state.
    always_comb begin
        digit_d  = digit_q;
        pre_d    = pre_q + 1'b1;
        idx_d    = idx_q;
        blank_d  = bus.blank;
        scan_adv = (pre_q == PRE_LAST);

        if (bus.load) begin
            digit_d = bus.digits_in;
        end

        if (scan_adv) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; zeros stay dark until the first nonzero code.
    always_comb begin
        logic seen;
        seen = 1'b0;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (digit_q[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            supp[i] = ~seen;
        end
    end
`else
    // Every digit is shown, leading zeros included.
    always_comb begin
        supp = '0;
    end
`endif

    // Pick the code and suppression flag of the currently scanned digit.
    always_comb begin
        sel_code = 4'd0;
        sel_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_code = digit_q[4*i +: 4];
                sel_supp = supp[i];
            end
        end
    end

    // Output pattern from current index and digit register; dark slot forces segments off.
    always_comb begin
        lit   = ~blank_q & ~sel_supp;
        an_d  = '1;
        seg_d = SEG_OFF;
        err_d = 1'b0;

        if (lit) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = decode(sel_code);
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q[4*i +: 4] > 4'd9) begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers; reset overrides load and blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            blank_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    assign bus.segments = seg_q;
    assign bus.anodes   = an_q;
    assign bus.code_err = err_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver, NUM_DIGITS=4, SCAN_DIV=4.
// Output at edge k after reset release shows digit (k/4)%4.
module tb_bcd_display_driver;

    localparam int ND = 4;
    localparam int SD = 4;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S8 = 7'h00;
    localparam logic [6:0] SD_ = 7'h3F;
    localparam logic [6:0] SOFF = 7'h7F;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   k;

    bcd_display_driver_if #(.NUM_DIGITS(ND)) bus ();

    bcd_display_driver #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [6:0] es,
                       input logic [3:0] ea, input logic ee);
        total++;
        assert (bus.segments === es) else begin
            bad++;
            $error("FAIL %s k=%0d segments got=%b exp=%b", tag, k, bus.segments, es);
        end
        total++;
        assert (bus.anodes === ea) else begin
            bad++;
            $error("FAIL %s k=%0d anodes got=%b exp=%b", tag, k, bus.anodes, ea);
        end
        total++;
        assert (bus.code_err === ee) else begin
            bad++;
            $error("FAIL %s k=%0d code_err got=%b exp=%b", tag, k, bus.code_err, ee);
        end
    endtask

    function automatic logic [3:0] an_at(input int kk);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((kk / SD) % ND));
    endfunction

    // Lit digit expected at the current edge index
    task automatic chk_lit(input string tag, input logic [6:0] es, input logic ee);
        chk(tag, es, an_at(k), ee);
    endtask

    // Digit that is dark only when leading-zero blanking is built in
    task automatic chk_lz(input string tag, input logic [6:0] es);
`ifdef LEADING_ZERO_BLANK_EN
        chk(tag, SOFF, 4'hF, 1'b0);
`else
        chk(tag, es, an_at(k), 1'b0);
`endif
    endtask

    initial begin
        logic [6:0] scan_tab [4];
        scan_tab[0] = S4;
        scan_tab[1] = S3;
        scan_tab[2] = S2;
        scan_tab[3] = S1;
        total = 0;
        bad   = 0;
        k     = 0;

        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.blank     = 1'b0;
        tick();
        tick();
        chk("reset", SOFF, 4'hF, 1'b0);

        // Release reset while loading 0x1234; edge 0 still shows cleared digit 0
        reset         = 1'b0;
        bus.load      = 1'b1;
        bus.digits_in = 16'h1234;
        k = -1;
        tick();
        chk("first_edge", S0, 4'hE, 1'b0);
        bus.load = 1'b0;

        // Full scan with wrap: 4,3,2,1 for 4 edges each
        for (int i = 1; i < 20; i++) begin
            tick();
            chk_lit("scan", scan_tab[(k / SD) % ND], 1'b0);
        end

        // Invalid code in digit 1, loaded at edge 20
        bus.load      = 1'b1;
        bus.digits_in = 16'h12A4;
        tick();
        chk_lit("pre_err", S3, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_lit("dash", SD_, 1'b1);
        tick();
        tick();
        chk_lit("dash_hold", SD_, 1'b1);

        // Reload good data at edge 24
        bus.load      = 1'b1;
        bus.digits_in = 16'h1234;
        tick();
        chk_lit("err_lag", S2, 1'b1);
        bus.load = 1'b0;
        tick();
        chk_lit("err_clr", S2, 1'b0);

        // Blank sampled at edges 26..31
        bus.blank = 1'b1;
        tick();
        chk_lit("blank_lag", S2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("blanked", SOFF, 4'hF, 1'b0);
        end
        bus.blank = 1'b0;
        tick();
        chk("blank_last", SOFF, 4'hF, 1'b0);
        tick();
        chk_lit("unblank", S4, 1'b0);

        // Load 0x0009 on the scan-advance edge 35
        tick();
        bus.load      = 1'b1;
        bus.digits_in = 16'h0009;
        tick();
        chk_lit("coll_pre", S4, 1'b0);
        bus.load = 1'b0;
        tick();
        chk_lz("coll_new", S0);

        // Leading zeros: 0x0050 loaded at edge 37
        bus.load      = 1'b1;
        bus.digits_in = 16'h0050;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        chk_lit("lz_d1", S5, 1'b0);
        tick();
        tick();
        chk_lz("lz_d2", S0);
        for (int i = 0; i < 4; i++) tick();
        chk_lz("lz_d3", S0);
        for (int i = 0; i < 4; i++) tick();
        chk_lit("lz_d0", S0, 1'b0);

        // All zeros loaded at edge 52
        tick();
        tick();
        bus.load      = 1'b1;
        bus.digits_in = 16'h0000;
        tick();
        bus.load = 1'b0;
        tick();
        chk_lz("z_d1", S0);
        for (int i = 0; i < 4; i++) tick();
        chk_lz("z_d2", S0);
        for (int i = 0; i < 4; i++) tick();
        chk_lz("z_d3", S0);
        for (int i = 0; i < 4; i++) tick();
        chk_lit("z_d0", S0, 1'b0);

        // Reset during digit 2 of 0x9876
        bus.load      = 1'b1;
        bus.digits_in = 16'h9876;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk_lit("d2_9876", S8, 1'b0);
        reset         = 1'b1;
        bus.load      = 1'b1;
        bus.blank     = 1'b1;
        tick();
        chk("mid_reset", SOFF, 4'hF, 1'b0);
        reset     = 1'b0;
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        k = -1;
        tick();
        chk("post_reset", S0, 4'hE, 1'b0);
        tick();
        chk("post_reset2", S0, 4'hE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Multiplexed seven-segment display driver for the microwave front panel. It latches a packed word of BCD digits (keypad entry or countdown time) and decodes each digit to segment patterns. It scans the digits one at a time with a programmable refresh rate. It is the display-side counterpart of the keypad encoder path: BCD in, segment and digit-select lines out.

## Interface
- `NUM_DIGITS`, default 4: number of display digits; digit 0 is least significant.
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected; legal range 2 or more.
- Clocking and reset: one clock, `clk`. Reset is `reset`, synchronous and active-high.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous active-high reset.
- `load`  input  1  when high, `digits_in` is captured at this edge.
- `digits_in`  input  4*NUM_DIGITS  packed BCD; bits [3:0] are digit 0.
- `blank`  input  1  when high, all digits are turned off; scanning continues.
- `segments`  output  7  active-low segment lines {g,f,e,d,c,b,a}; registered.
- `anodes`  output  NUM_DIGITS  active-low digit enables, at most one low; registered.
- `code_err`  output  1  registered; high while any latched digit code is greater than 9.

## Operation
- Digit register: cleared by reset. Loaded from `digits_in` on any edge with `load`=1. Holds its value otherwise.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. The terminal count (SCAN_DIV-1) advances the scan index.
- Scan index: counts 0..NUM_DIGITS-1 and wraps to 0. Non-power-of-two `NUM_DIGITS` must wrap correctly; no unused index is ever selected.
- Decode of the selected digit, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10-15 display a dash, 0111111.
- `anodes`: bit [index] low, all others high. All high when `blank`=1 or when the selected digit is suppressed (see Configuration).
- `segments`: decoded pattern of the selected digit. Forced to 1111111 whenever the anodes are all high.
- `code_err`: OR over all latched digits of (code > 9), registered.

## Timing
- Reset values:
  - `segments`=1111111
  - `anodes`=all ones
  - `code_err`=0
  - digit register 0, prescaler 0, scan index 0
- First edge after reset deasserts: outputs show digit 0 (anodes=...1110, segments=1000000).
- Outputs are registered from the current index and digit register. A change is visible one edge after the internal state changes.
- Load latency: `load` sampled high at edge N updates the register at N. The new pattern appears at edge N+1 if that digit is selected. `code_err` also updates at N+1.
- Dwell time: each digit stays selected for exactly SCAN_DIV cycles. Full refresh period is NUM_DIGITS*SCAN_DIV cycles.
- `load` on the same edge as a scan advance: both take effect. The next output shows the new index with the new data.
- `blank`: sampled at edge N; anodes go all high at edge N+1. Deasserting `blank` restores the display at the next edge with no re-phasing of the scan.
- `reset` mid-scan: all state returns to reset values at that edge, regardless of `load` and `blank`.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Starting from digit NUM_DIGITS-1 downward, each digit whose latched code is 0 is suppressed until the first nonzero digit.
  - Codes 10-15 count as nonzero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its full dwell slot, with anodes all high and segments 1111111.
- Not defined: every digit is always displayed, including leading zeros.

## Test plan
- Reset and scan, SCAN_DIV=4, NUM_DIGITS=4: load 0x1234 → digits 0..3 show 4,3,2,1 for 4 cycles each. Anodes cycle 1110,1101,1011,0111 and wrap. `code_err`=0.
- Invalid code: load 0x12A4 → digit 1 shows 0111111 and `code_err`=1 one edge after load. Loading 0x1234 returns `code_err` to 0.
- Blank: assert `blank` for 6 cycles mid-scan → anodes=1111 and segments=1111111 from the next edge. On release, the scan index equals the value it would have had without blanking.
- Load collision: pulse `load` with 0x0009 on the scan-advance edge → the next output is the new digit with the new value, no stale frame.
- Leading zeros, macro defined: load 0x0050 → digits 3 and 2 are dark, digit 1 shows 5, digit 0 shows 0. Load 0x0000 → only digit 0 lit, showing 0. Macro undefined: all four digits lit.
- Reset mid-operation: assert `reset` during digit 2 of 0x9876 with `load`=1 → next edge all outputs at reset values. After release, digit 0 shows 0.
